push_cursor_ctrl: RTL and testbench
===================================

Name: push_cursor_ctrl

Overview:
Conditions the raw board pushbuttons and produces the edit controls for the up/down counter stage of the clock/timer/date design. Outputs are single-cycle push_up and push_down pulses, with auto-repeat while held. It also maintains the 5-bit field-select cursor counterlr, which moves with the left/right buttons. Sits directly upstream of the counters and drives their push_up, push_down and counterlr inputs.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz)
REPEAT_DELAY, 50000000, cycles from the first up/down pulse to the first auto-repeat pulse while held
REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat pulses
CURSOR_MAX, 8, number of cursor positions; counterlr range is 0..CURSOR_MAX-1, with CURSOR_MAX <= 32

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
btn_up  input  1  raw asynchronous up button, active high
btn_down  input  1  raw down button
btn_left  input  1  raw cursor-left button
btn_right  input  1  raw cursor-right button
edit_en  input  1  editing enabled (the sw setting switch); 0 = run mode
push_up  output  1  one-cycle increment pulse
push_down  output  1  one-cycle decrement pulse
counterlr  output  5  cursor / field select

Behaviour:
- Reset (async, active-high): all synchronizers, debounced levels, counters and FSM cleared; push_up=0, push_down=0, counterlr=0.
- Per button: a 2-FF synchronizer, then a debouncer.
  - Debouncer counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. At count DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
- Latency: the first clock edge sampling a raw level change that stays stable begins a path ending in the output pulse. That pulse is high in the cycle following edge number DEBOUNCE_CYCLES+3, counting the sampling edge as edge 1.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no output.
- Up/down repeat FSM, states IDLE, FIRST, WAIT, REPEAT:
  - IDLE: exactly one debounced up/down high with a rising edge -> FIRST. Records the direction.
  - FIRST: emit one pulse in the recorded direction -> WAIT. Load the timer with REPEAT_DELAY-1.
  - WAIT: timer counts down; at 0 with the button still held -> REPEAT (pulse), timer reloads REPEAT_PERIOD-1.
  - REPEAT: pulse at each timer 0 while held, so the spacing is REPEAT_PERIOD cycles.
  - Release of the recorded button in any state -> IDLE, no pulse.
  - Both up and down debounced high: no pulses. FSM goes to IDLE and stays there until both are released.
  - Pressing the opposite button while holding one: treated as "both", so repeat stops.
- Left/right have no auto-repeat. A debounced rising edge gives one step.
  - Right: counterlr+1, wrapping CURSOR_MAX-1 -> 0.
  - Left: counterlr-1, wrapping 0 -> CURSOR_MAX-1.
  - Left and right edges in the same cycle: no change.
- edit_en=0: push_up and push_down held 0, FSM forced to IDLE, counterlr forced to 0 synchronously. Debouncers keep running.
  - A button already held when edit_en rises produces no pulse until it is released and pressed again.
- push_up and push_down are registered and never both high. Each pulse is exactly 1 cycle wide.

Decomposition:
- Shared package:
  - CURSOR_W = 5
  - FSM state enum (IDLE, FIRST, WAIT, REPEAT)
  - direction constants DIR_UP and DIR_DOWN
- Sub-module push_debouncer (params DEBOUNCE_CYCLES; ports clk, reset, raw, level, rise): 2-FF synchronizer, debouncer and rising-edge detect. Instantiated 4 times.
- Top holds the repeat FSM, its timer (width $clog2 of the max of REPEAT_DELAY and REPEAT_PERIOD) and the cursor register.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, CURSOR_MAX=8, edit_en=1 unless stated.
- Reset: assert reset mid-cycle with buttons held -> outputs 0 immediately; after release no pulse until a new press.
- Debounce: btn_up high 3 cycles then low -> no pulse. btn_up held -> push_up high for 1 cycle, 7 edges after the first sampling edge.
- Auto-repeat: hold btn_down 60 cycles -> pulses at t0, t0+20, t0+25, t0+30, t0+35 ...; release -> pulses stop within 7 cycles.
- Cursor wrap: 9 btn_right presses from 0 -> counterlr 1,2,...,7,0,1. btn_left at 0 -> 7.
- Conflicts: btn_up and btn_down pressed together -> no pulses. btn_left and btn_right rising in the same cycle -> counterlr unchanged.
- edit_en: counterlr=5, drop edit_en -> counterlr=0 and pressing btn_up gives no push_up. Raise edit_en while btn_up is held -> no pulse until it is released and re-pressed.

Source files
------------

// File: rtl/push_cursor_ctrl_pkg.sv
// Shared types and constants for the pushbutton / cursor controller.
// Holds the repeat FSM state encoding and direction codes.
package push_cursor_ctrl_pkg;

    localparam int unsigned CURSOR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPEAT = 2'd3
    } rep_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/push_debouncer.sv
// One button: 2-FF synchronizer, counting debouncer, rise pulse.
// rise is high for the single cycle after level goes 0 -> 1.
module push_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bring the raw asynchronous level into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has been stable long enough.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/push_cursor_ctrl.sv
// Button conditioning for the counter edit path: up/down pulses
// with auto-repeat, and the left/right field-select cursor.
module push_cursor_ctrl
    import push_cursor_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000,
    parameter int unsigned CURSOR_MAX      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                edit_en,
    output logic                push_up,
    output logic                push_down,
    output logic [CURSOR_W-1:0] counterlr
);

    localparam int unsigned RMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
    localparam logic [CURSOR_W-1:0] CUR_LAST = CURSOR_W'(CURSOR_MAX - 1);

    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic lf_lvl, lf_rise;
    logic rt_lvl, rt_rise;

    push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .raw(btn_up),
        .level(up_lvl), .rise(up_rise)
    );
    push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk(clk), .reset(reset), .raw(btn_down),
        .level(dn_lvl), .rise(dn_rise)
    );
    push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lf (
        .clk(clk), .reset(reset), .raw(btn_left),
        .level(lf_lvl), .rise(lf_rise)
    );
    push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rt (
        .clk(clk), .reset(reset), .raw(btn_right),
        .level(rt_lvl), .rise(rt_rise)
    );

    rep_state_e          state_q;
    logic                dir_q;
    logic [TW-1:0]       timer_q;
    logic                push_up_q, push_dn_q;
    logic [CURSOR_W-1:0] cur_q, cur_d;
    logic                held;

    assign held = (dir_q == DIR_UP) ? up_lvl : dn_lvl;

    // Repeat FSM: first pulse on press, then delay, then periodic.
    // The FIRST cycle is the one in which the first pulse is visible;
    // the timer is loaded together with that pulse so spacing is exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            timer_q   <= '0;
            push_up_q <= 1'b0;
            push_dn_q <= 1'b0;
        end else begin
            push_up_q <= 1'b0;
            push_dn_q <= 1'b0;
            if (!edit_en || (up_lvl && dn_lvl)) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (up_rise) begin
                            state_q   <= ST_FIRST;
                            dir_q     <= DIR_UP;
                            timer_q   <= T_DELAY;
                            push_up_q <= 1'b1;
                        end else if (dn_rise) begin
                            state_q   <= ST_FIRST;
                            dir_q     <= DIR_DOWN;
                            timer_q   <= T_DELAY;
                            push_dn_q <= 1'b1;
                        end
                    end
                    ST_FIRST, ST_WAIT, ST_REPEAT: begin
                        if (!held) begin
                            state_q <= ST_IDLE;
                        end else if (timer_q == '0) begin
                            state_q   <= ST_REPEAT;
                            timer_q   <= T_PERIOD;
                            push_up_q <= (dir_q == DIR_UP);
                            push_dn_q <= (dir_q == DIR_DOWN);
                        end else begin
                            if (state_q == ST_FIRST) begin
                                state_q <= ST_WAIT;
                            end
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Next cursor position: one step per edge, wrapping both ways.
    always_comb begin
        cur_d = cur_q;
        if (!edit_en) begin
            cur_d = '0;
        end else if (rt_rise && !lf_rise) begin
            cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + CURSOR_W'(1);
        end else if (lf_rise && !rt_rise) begin
            cur_d = (cur_q == '0) ? CUR_LAST : cur_q - CURSOR_W'(1);
        end
    end

    // Cursor register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign push_up   = push_up_q;
    assign push_down = push_dn_q;
    assign counterlr = cur_q;

endmodule

// File: tb/tb_push_cursor_ctrl.sv
// Directed bench for push_cursor_ctrl with small timing parameters.
// Pulses are logged by cycle number and compared to hand values.
module tb_push_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       edit_en;
    logic       push_up, push_down;
    logic [4:0] counterlr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int up_cnt   = 0;
    int dn_cnt   = 0;
    int both_seen = 0;
    int dn_q[$];

    push_cursor_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5),
        .CURSOR_MAX(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .edit_en(edit_en),
        .push_up(push_up),
        .push_down(push_down),
        .counterlr(counterlr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (push_up) up_cnt++;
        if (push_down) begin
            dn_cnt++;
            dn_q.push_back(cyc);
        end
        if (push_up && push_down) both_seen++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel: 0 up, 1 down, 2 left, 3 right, 4 left+right
    task automatic press(input int sel);
        case (sel)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_left = 1'b1;
            3: btn_right = 1'b1;
            default: begin btn_left = 1'b1; btn_right = 1'b1; end
        endcase
        tick(10);
        btn_up = 1'b0; btn_down = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0;
        tick(10);
    endtask

    function automatic int dn_at(input int idx, input int base);
        if (idx < dn_q.size()) return dn_q[idx] - base;
        return -1;
    endfunction

    initial begin
        int e0, nu, nd;
        reset = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0;
        edit_en = 1'b1;
        tick(3);
        chk("rst_up", int'(push_up), 0);
        chk("rst_dn", int'(push_down), 0);
        chk("rst_cur", int'(counterlr), 0);
        reset = 1'b0;
        tick(2);

        // glitch of 3 cycles is filtered
        nu = up_cnt;
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        tick(20);
        chk("glitch", up_cnt, nu);

        // latency: pulse after edge 7, one cycle wide
        btn_up = 1'b1;
        tick(6);
        chk("lat_pre", int'(push_up), 0);
        tick(1);
        chk("lat_pulse", int'(push_up), 1);
        tick(1);
        chk("lat_width", int'(push_up), 0);
        btn_up = 1'b0;
        tick(15);
        chk("lat_count", up_cnt, nu + 1);

        // auto-repeat on down
        nu = up_cnt;
        dn_q.delete();
        btn_down = 1'b1;
        e0 = cyc;
        tick(60);
        btn_down = 1'b0;
        tick(30);
        chk("rep_count", dn_q.size(), 9);
        chk("rep_t0", dn_at(0, e0), 7);
        chk("rep_t1", dn_at(1, e0), 27);
        chk("rep_t2", dn_at(2, e0), 32);
        chk("rep_t3", dn_at(3, e0), 37);
        chk("rep_last", dn_at(8, e0), 62);
        chk("rep_no_up", up_cnt, nu);

        // up and down together
        nu = up_cnt;
        nd = dn_cnt;
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(40);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(20);
        chk("both_up", up_cnt, nu);
        chk("both_dn", dn_cnt, nd);

        // cursor wrap
        for (int i = 1; i <= 9; i++) begin
            press(3);
            chk($sformatf("right%0d", i), int'(counterlr), i % 8);
        end
        press(2);
        chk("left_to0", int'(counterlr), 0);
        press(2);
        chk("left_wrap", int'(counterlr), 7);
        press(4);
        chk("lr_same", int'(counterlr), 7);
        press(2);
        press(2);
        chk("cur5", int'(counterlr), 5);

        // edit_en low
        edit_en = 1'b0;
        tick(1);
        chk("edit_cur0", int'(counterlr), 0);
        nu = up_cnt;
        press(0);
        chk("edit_off_up", up_cnt, nu);
        btn_up = 1'b1;
        tick(10);
        edit_en = 1'b1;
        tick(40);
        chk("edit_held", up_cnt, nu);
        btn_up = 1'b0;
        tick(10);
        press(0);
        chk("edit_repress", up_cnt, nu + 1);

        // async reset mid-cycle while a pulse is high
        press(3);
        chk("pre_rst_cur", int'(counterlr), 1);
        btn_up = 1'b1;
        tick(7);
        chk("pre_rst_up", int'(push_up), 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_up", int'(push_up), 0);
        chk("arst_cur", int'(counterlr), 0);
        btn_up = 1'b0;
        tick(3);
        reset = 1'b0;
        nu = up_cnt;
        tick(30);
        chk("post_rst_quiet", up_cnt, nu);
        press(0);
        chk("post_rst_press", up_cnt, nu + 1);

        chk("never_both", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
